frame_scheduler: RTL
====================

# frame_scheduler

Double-buffer controller for the LED panel framebuffer. Sits between the frame writer (GIF decode/loader) and the panel scan driver. Owns which RAM bank the driver scans and which bank the writer fills. Swaps banks only on full-refresh boundaries, after the current frame's display duration, counted in panel refreshes, has expired.

## Interface
- ADDR_W, 12, driver-side framebuffer address width
- ROWS, 32, row strobes per full panel refresh
- DELAY_W, 16, width of per-frame display duration
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_row_stb  in  1  one-cycle pulse from scan driver per row latched
- i_drv_addr  in  ADDR_W  scan driver read address
- o_ram_rd_addr  out  ADDR_W+1  {front_bank, i_drv_addr}, combinational
- i_wr_valid  in  1  writer has finished filling back bank
- i_wr_delay  in  DELAY_W  refreshes to show that frame, sampled on handshake
- o_wr_ready  out  1  back bank owned by writer, handshake accepted
- o_wr_bank  out  1  bank the writer must fill (always ~front)
- o_front_bank  out  1  bank currently scanned
- o_display_en  out  1  low until first frame shown; gates driver blanking
- o_frame_stb  out  1  one-cycle pulse per full refresh
- o_swap_stb  out  1  one-cycle pulse on bank swap
- o_stall_count  out  16  refreshes repeated for lack of a new frame

## Operation
- Row counter 0..ROWS-1 increments on i_row_stb. Boundary = i_row_stb while counter==ROWS-1. Counter wraps to 0 and o_frame_stb fires the next cycle.
- Handshake: transfer when i_wr_valid && o_wr_ready on a rising edge. It sets pending, latches delay (0 treated as 1), and drops o_wr_ready the next cycle.
- States:
  - IDLE: display_en=0. On a boundary with pending set: swap, go SHOW.
  - SHOW: on each boundary, remaining-=1. At the boundary where remaining==1: if pending, swap (stay SHOW). Else go HOLD.
  - HOLD: current frame repeats. Each boundary without pending increments stall count. First boundary with pending: swap, go SHOW.
- Swap (one cycle):
  - front_bank toggles.
  - remaining loads latched delay.
  - pending clears.
  - o_swap_stb=1.
  - display_en=1.
  - o_wr_ready reasserts the next cycle.
- Pending is registered. A handshake in the same cycle as a boundary is not eligible until the following boundary.
- Writer must not assert i_wr_valid before it has finished writing. Once o_wr_ready deasserts, it must not touch bank o_wr_bank until o_wr_ready returns.
- o_wr_bank and o_ram_rd_addr MSB change only on swap cycles. They are never mid-refresh.
- Delay arithmetic: unsigned DELAY_W. Remaining never underflows.
- Reset mid-operation:
  - all state returns to reset values.
  - A pending frame is discarded.
  - Writer sees o_wr_ready=1 and must refill.

## Timing
- Reset values:
  - front_bank=0
  - o_wr_bank=1
  - o_wr_ready=1
  - o_display_en=0
  - o_frame_stb=0
  - o_swap_stb=0
  - o_stall_count=0
  - row counter=0
  - remaining=0
  - state IDLE
- Swap takes effect on the edge that samples the boundary strobe. o_swap_stb, the new o_front_bank and o_frame_stb are all visible the next cycle.
- o_wr_ready falls 1 cycle after the handshake and rises 1 cycle after the swap.
- Minimum writer turnaround is ROWS row strobes (one refresh).

## Configuration
- FRAME_SCHED_STATS_EN defined: o_stall_count counts HOLD boundaries without a swap. It saturates at 0xFFFF and clears only on reset.
- Not defined: counter logic is omitted and o_stall_count is tied to 0.

## Structure
- Shared package panel_pkg:
  - state enum (IDLE, SHOW, HOLD)
  - ROWS default
  - DELAY_W default
  - bank-select constants
- One sub-module, row_boundary_counter, takes i_row_stb and outputs a boundary pulse. It is parameterised by ROWS.

## Test plan
- Reset, then accept a frame with delay=3. Expect: swap at first boundary (front 0→1, display_en 1), o_wr_bank=0, o_wr_ready high 1 cycle after swap.
- Frame A shown with delay=3, frame B handshaked during refresh 1. Expect: swap exactly at the 3rd boundary after A's swap, not earlier.
- Delay=2, no new frame. Expect: HOLD, same bank repeated. With the stats macro, stall count reaches 4 after 4 further boundaries. A handshake then swaps at the next boundary.
- Handshake in the same cycle as the expiring boundary. Expect: no swap that boundary, swap at the next one.
- i_wr_delay=0. Expect: behaves as 1, swap on each boundary while frames keep arriving.
- Reset asserted in HOLD with pending set. Expect: all outputs at reset values the next cycle and pending dropped. No swap at the following boundary without a new handshake.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared types and defaults for the LED panel double-buffer scheduler.
package panel_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int ROWS_DEF    = 32;
  localparam int DELAY_W_DEF = 16;
  localparam int STALL_W     = 16;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Writer-side handshake between the frame loader and the frame scheduler.
interface frame_scheduler_if #(
  parameter int DELAY_W = panel_pkg::DELAY_W_DEF
);
  logic               i_wr_valid;
  logic [DELAY_W-1:0] i_wr_delay;
  logic               o_wr_ready;
  logic               o_wr_bank;

  modport master (
    output i_wr_valid,
    output i_wr_delay,
    input  o_wr_ready,
    input  o_wr_bank
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_delay,
    output o_wr_ready,
    output o_wr_bank
  );
endinterface

// File: rtl/row_boundary_counter.sv
// Counts row strobes and flags the strobe that completes a full panel refresh.
module row_boundary_counter #(
  parameter int ROWS = panel_pkg::ROWS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_row_stb,
  output logic o_boundary
);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);

  logic [CNT_W-1:0] row_q;

  assign o_boundary = i_row_stb && (row_q == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_q <= '0;
    end else if (i_row_stb) begin
      row_q <= o_boundary ? '0 : row_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/frame_scheduler.sv
// Double-buffer bank controller: swaps scan/fill banks on refresh boundaries.
// Define FRAME_SCHED_STATS_EN to build the saturating stall counter.
module frame_scheduler
  import panel_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_row_stb,
  input  logic [ADDR_W-1:0]  i_drv_addr,
  output logic [ADDR_W:0]    o_ram_rd_addr,
  frame_scheduler_if.slave   wr,
  output logic               o_front_bank,
  output logic               o_display_en,
  output logic               o_frame_stb,
  output logic               o_swap_stb,
  output logic [STALL_W-1:0] o_stall_count
);
  sched_state_t       state_q, state_n;
  logic [DELAY_W-1:0] remaining_q, remaining_n;
  logic [DELAY_W-1:0] delay_q, delay_n;
  logic               pending_q, pending_n;
  logic               front_q, front_n;
  logic               swap_q, swap_n;
  logic               disp_q, disp_n;
  logic               frame_q;
  logic               boundary;
  logic               handshake;
  logic               do_swap;

  row_boundary_counter #(.ROWS(ROWS)) u_rows (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_row_stb  (i_row_stb),
    .o_boundary (boundary)
  );

  // Ready is exactly "no frame pending": it falls after a handshake and
  // returns together with the swap that consumes the pending frame.
  assign handshake      = wr.i_wr_valid && !pending_q;
  assign wr.o_wr_ready  = !pending_q;
  assign wr.o_wr_bank   = !front_q;
  assign o_front_bank   = front_q;
  assign o_ram_rd_addr  = {front_q, i_drv_addr};
  assign o_display_en   = disp_q;
  assign o_frame_stb    = frame_q;
  assign o_swap_stb     = swap_q;

  always_comb begin
    state_n     = state_q;
    remaining_n = remaining_q;
    delay_n     = delay_q;
    pending_n   = pending_q;
    front_n     = front_q;
    swap_n      = 1'b0;
    disp_n      = disp_q;
    do_swap     = 1'b0;

    if (handshake) begin
      pending_n = 1'b1;
      delay_n   = (wr.i_wr_delay == '0) ? DELAY_W'(1) : wr.i_wr_delay;
    end

    if (boundary) begin
      case (state_q)
        IDLE: do_swap = pending_q;
        SHOW: begin
          if (remaining_q <= DELAY_W'(1)) begin
            if (pending_q) begin
              do_swap = 1'b1;
            end else begin
              state_n     = HOLD;
              remaining_n = '0;
            end
          end else begin
            remaining_n = remaining_q - DELAY_W'(1);
          end
        end
        HOLD:    do_swap = pending_q;
        default: state_n = IDLE;
      endcase
    end

    // A handshake can never coincide with a swap: both key off pending_q.
    if (do_swap) begin
      state_n     = SHOW;
      front_n     = !front_q;
      remaining_n = delay_q;
      pending_n   = 1'b0;
      swap_n      = 1'b1;
      disp_n      = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      delay_q     <= '0;
      pending_q   <= 1'b0;
      front_q     <= BANK_A;
      swap_q      <= 1'b0;
      disp_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      remaining_q <= remaining_n;
      delay_q     <= delay_n;
      pending_q   <= pending_n;
      front_q     <= front_n;
      swap_q      <= swap_n;
      disp_q      <= disp_n;
      frame_q     <= boundary;
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q <= '0;
    end else if (state_q == HOLD && boundary && !pending_q && stall_q != '1) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign o_stall_count = stall_q;
`else
  assign o_stall_count = '0;
`endif

endmodule
